// File: rtl/game_pkg.sv
// Shared game definitions: game-state encodings, playfield and brick geometry.
package game_pkg;

    localparam logic [2:0] mainMenu  = 3'd0;
    localparam logic [2:0] level1    = 3'd1;
    localparam logic [2:0] endScreen = 3'd2;

    localparam int SCREEN_W_PX = 160;
    localparam int SCREEN_H_PX = 120;
    localparam int PADDLE_Y_PX = 110;
    localparam int PADDLE_W_PX = 24;
    localparam int BRICK_Y0_PX = 16;

    localparam int BRICK_W     = 16;
    localparam int BRICK_H     = 8;
    localparam int BRICK_COLS  = 10;
    localparam int BRICK_ROWS  = 4;
    localparam int BRICK_COUNT = 40;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_ARMED,
        CTRL_CLEARED
    } ctrl_state_e;

    function automatic logic [5:0] brick_bit(input logic [1:0] row, input logic [3:0] col);
        return ({4'b0, row} * 6'(BRICK_COLS)) + {2'b0, col};
    endfunction

endpackage

// File: rtl/brick_index.sv
// Maps a pixel position to its brick cell; shared with the renderer.
module brick_index
    import game_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_PX,
    parameter int BRICK_Y0 = BRICK_Y0_PX
) (
    input  logic [7:0] i_ball_x,
    input  logic [7:0] i_ball_y,
    output logic       o_valid,
    output logic [1:0] o_row,
    output logic [3:0] o_col,
    output logic [5:0] o_bit
);

    localparam logic [7:0] Y_LO = 8'(BRICK_Y0);
    localparam logic [8:0] Y_HI = 9'(BRICK_Y0 + BRICK_ROWS * BRICK_H);
    localparam logic [7:0] X_HI = 8'(SCREEN_W);

    logic [7:0] w_dy;

    always_comb begin
        w_dy    = i_ball_y - Y_LO;
        o_valid = (i_ball_y >= Y_LO) && ({1'b0, i_ball_y} < Y_HI) && (i_ball_x < X_HI);
        o_row   = 2'(w_dy >> 3);
        o_col   = i_ball_x[7:4];
        // Out-of-field positions map to bit 0 so the index never leaves the map.
        o_bit   = o_valid ? brick_bit(o_row, o_col) : 6'd0;
    end

endmodule

// File: rtl/collision_unit.sv
// Per-tick wall/paddle/brick collision detector; owns the brick map and score.
module collision_unit
    import game_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_PX,
    parameter int SCREEN_H = SCREEN_H_PX,
    parameter int PADDLE_Y = PADDLE_Y_PX,
    parameter int PADDLE_W = PADDLE_W_PX,
    parameter int BRICK_Y0 = BRICK_Y0_PX
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  state,
    input  logic        tick,
    input  logic [7:0]  ballX,
    input  logic [7:0]  ballY,
    input  logic [7:0]  paddleX,
    output logic        cX,
    output logic        cY,
    output logic        cBrickX,
    output logic        cBrickY,
    output logic        miss,
    output logic [39:0] brickMap,
    output logic [7:0]  score,
    output logic [5:0]  bricksLeft,
    output logic        levelClear
);

    localparam logic [7:0] X_RIGHT   = 8'(SCREEN_W - 1);
    localparam logic [7:0] Y_BOTTOM  = 8'(SCREEN_H - 1);
    localparam logic [7:0] PAD_ROW   = 8'(PADDLE_Y);
    localparam logic [8:0] PAD_WIDTH = 9'(PADDLE_W);
    localparam logic [5:0] ALL_LEFT  = 6'(BRICK_COUNT);

    ctrl_state_e r_ctrl, r_ctrl_next;

    logic        r_cx, r_cy, r_cbx, r_cby, r_miss;
    logic [39:0] r_brick_map;
    logic [7:0]  r_score;
    logic [5:0]  r_bricks_left;
    logic        r_level_clear;
    logic [3:0]  r_prev_col;

    logic        w_valid;
    logic [1:0]  w_row;
    logic [3:0]  w_col;
    logic [5:0]  w_bit;
    logic [9:0]  w_row_bits;
    logic        w_in_level, w_load, w_check, w_hit, w_on_paddle;
    logic [8:0]  w_paddle_end;

    brick_index #(
        .SCREEN_W (SCREEN_W),
        .BRICK_Y0 (BRICK_Y0)
    ) u_brick_index (
        .i_ball_x (ballX),
        .i_ball_y (ballY),
        .o_valid  (w_valid),
        .o_row    (w_row),
        .o_col    (w_col),
        .o_bit    (w_bit)
    );

    always_comb begin
        w_in_level   = (state == level1);
        w_load       = (r_ctrl == CTRL_IDLE) && w_in_level;
        w_check      = (r_ctrl == CTRL_ARMED) && w_in_level && tick;
        w_row_bits   = r_brick_map[brick_bit(w_row, 4'd0) +: 10];
        w_hit        = w_check && w_valid && w_row_bits[w_col];
        w_paddle_end = {1'b0, paddleX} + PAD_WIDTH;
        w_on_paddle  = (ballY == PAD_ROW) && (ballX >= paddleX) && ({1'b0, ballX} < w_paddle_end);
    end

    always_comb begin
        r_ctrl_next = r_ctrl;
        case (r_ctrl)
            CTRL_IDLE:    if (w_in_level) r_ctrl_next = CTRL_ARMED;
            CTRL_ARMED: begin
                if (!w_in_level)
                    r_ctrl_next = CTRL_IDLE;
                else if (r_bricks_left == 6'd0 || (w_hit && r_bricks_left == 6'd1))
                    r_ctrl_next = CTRL_CLEARED;
            end
            CTRL_CLEARED: if (!w_in_level) r_ctrl_next = CTRL_IDLE;
            default:      r_ctrl_next = CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ctrl        <= CTRL_IDLE;
            r_cx          <= 1'b0;
            r_cy          <= 1'b0;
            r_cbx         <= 1'b0;
            r_cby         <= 1'b0;
            r_miss        <= 1'b0;
            r_brick_map   <= '1;
            r_score       <= 8'd0;
            r_bricks_left <= ALL_LEFT;
            r_level_clear <= 1'b0;
            r_prev_col    <= 4'd0;
        end else begin
            r_ctrl <= r_ctrl_next;
            r_cx   <= w_check && (ballX == 8'd0 || ballX >= X_RIGHT);
            r_cy   <= w_check && (ballY == 8'd0 || w_on_paddle);
            r_miss <= w_check && (ballY >= Y_BOTTOM);
            // Same column as last tick means the ball entered through a top/bottom face.
            r_cby  <= w_hit && (r_prev_col == w_col);
            r_cbx  <= w_hit && (r_prev_col != w_col);
            if (tick)
                r_prev_col <= ballX[7:4];
            if (w_load) begin
                r_brick_map   <= '1;
                r_bricks_left <= ALL_LEFT;
                r_score       <= 8'd0;
                r_level_clear <= 1'b0;
            end else if (w_hit) begin
                r_brick_map[w_bit] <= 1'b0;
                r_bricks_left      <= r_bricks_left - 6'd1;
                if (r_score != 8'hFF)
                    r_score <= r_score + 8'd1;
                if (r_bricks_left == 6'd1)
                    r_level_clear <= 1'b1;
            end
        end
    end

    assign cX         = r_cx;
    assign cY         = r_cy;
    assign cBrickX    = r_cbx;
    assign cBrickY    = r_cby;
    assign miss       = r_miss;
    assign brickMap   = r_brick_map;
    assign score      = r_score;
    assign bricksLeft = r_bricks_left;
    assign levelClear = r_level_clear;

endmodule

// File: tb/tb_collision_unit.sv
// Directed self-checking bench for collision_unit.
module tb_collision_unit;
    import game_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  state;
    logic        tick;
    logic [7:0]  ballX, ballY, paddleX;
    logic        cX, cY, cBrickX, cBrickY, miss;
    logic [39:0] brickMap;
    logic [7:0]  score;
    logic [5:0]  bricksLeft;
    logic        levelClear;

    int checks   = 0;
    int failures = 0;

    // Pulses packed as {cX, cY, cBrickX, cBrickY, miss}
    logic [4:0] pulses_now, pulses_after;

    collision_unit dut (
        .clock      (clock),
        .reset      (reset),
        .state      (state),
        .tick       (tick),
        .ballX      (ballX),
        .ballY      (ballY),
        .paddleX    (paddleX),
        .cX         (cX),
        .cY         (cY),
        .cBrickX    (cBrickX),
        .cBrickY    (cBrickY),
        .miss       (miss),
        .brickMap   (brickMap),
        .score      (score),
        .bricksLeft (bricksLeft),
        .levelClear (levelClear)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick_at(input logic [7:0] x, input logic [7:0] y);
        @(negedge clock);
        ballX = x;
        ballY = y;
        tick  = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        pulses_now = {cX, cY, cBrickX, cBrickY, miss};
        @(negedge clock);
        pulses_after = {cX, cY, cBrickX, cBrickY, miss};
    endtask

    task automatic enter_level();
        @(negedge clock);
        state = mainMenu;
        @(negedge clock);
        state = level1;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        state   = mainMenu;
        tick    = 1'b0;
        ballX   = 8'd0;
        ballY   = 8'd60;
        paddleX = 8'd60;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        check_eq("reset_pulses", {cX, cY, cBrickX, cBrickY, miss}, 5'b00000);
        check_eq("reset_map", brickMap, 40'hFF_FFFF_FFFF);
        check_eq("reset_left", bricksLeft, 6'd40);
        check_eq("reset_score", score, 8'd0);
        check_eq("reset_clear", levelClear, 1'b0);

        enter_level();
        check_eq("load_map", brickMap, 40'hFF_FFFF_FFFF);
        check_eq("load_left", bricksLeft, 6'd40);
        check_eq("load_score", score, 8'd0);

        tick_at(8'd0, 8'd60);
        check_eq("wall_left_cx", pulses_now, 5'b10000);
        check_eq("wall_left_gone", pulses_after, 5'b00000);
        tick_at(8'd159, 8'd60);
        check_eq("wall_right_cx", pulses_now, 5'b10000);
        tick_at(8'd80, 8'd0);
        check_eq("wall_top_cy", pulses_now, 5'b01000);
        check_eq("wall_top_gone", pulses_after, 5'b00000);

        tick_at(8'd83, 8'd110);
        check_eq("paddle_last_px", pulses_now, 5'b01000);
        tick_at(8'd84, 8'd110);
        check_eq("paddle_past_end", pulses_now, 5'b00000);
        tick_at(8'd60, 8'd110);
        check_eq("paddle_first_px", pulses_now, 5'b01000);
        tick_at(8'd59, 8'd110);
        check_eq("paddle_before", pulses_now, 5'b00000);
        tick_at(8'd50, 8'd119);
        check_eq("bottom_miss", pulses_now, 5'b00001);
        check_eq("bottom_miss_gone", pulses_after, 5'b00000);

        tick_at(8'd35, 8'd60);
        tick_at(8'd35, 8'd20);
        check_eq("brick_vert_pulse", pulses_now, 5'b00010);
        check_eq("brick_vert_gone", pulses_after, 5'b00000);
        check_eq("brick_vert_map", brickMap, 40'hFF_FFFF_FFFB);
        check_eq("brick_vert_score", score, 8'd1);
        check_eq("brick_vert_left", bricksLeft, 6'd39);
        tick_at(8'd35, 8'd20);
        check_eq("brick_repeat", pulses_now, 5'b00000);
        check_eq("brick_repeat_left", bricksLeft, 6'd39);

        // Leaving level1 on a tick cycle: exit wins, results held.
        @(negedge clock);
        state = endScreen;
        ballX = 8'd0;
        ballY = 8'd20;
        tick  = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        check_eq("exit_no_pulse", {cX, cY, cBrickX, cBrickY, miss}, 5'b00000);
        check_eq("exit_hold_map", brickMap, 40'hFF_FFFF_FFFB);
        check_eq("exit_hold_score", score, 8'd1);
        tick_at(8'd0, 8'd60);
        check_eq("idle_tick_silent", pulses_now, 5'b00000);

        enter_level();
        check_eq("reload_map", brickMap, 40'hFF_FFFF_FFFF);
        check_eq("reload_score", score, 8'd0);
        tick_at(8'd31, 8'd60);
        tick_at(8'd33, 8'd20);
        check_eq("brick_horiz_pulse", pulses_now, 5'b00100);
        check_eq("brick_horiz_map", brickMap, 40'hFF_FFFF_FFFB);
        tick_at(8'd0, 8'd20);
        check_eq("wall_and_brick", pulses_now, 5'b10100);
        check_eq("wall_and_brick_map", brickMap, 40'hFF_FFFF_FFFA);
        check_eq("wall_and_brick_score", score, 8'd2);
        check_eq("wall_and_brick_left", bricksLeft, 6'd38);

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 10; c++) begin
                tick_at(8'(c * 16 + 8), 8'(16 + r * 8 + 4));
            end
        end
        check_eq("clear_map", brickMap, 40'h0);
        check_eq("clear_left", bricksLeft, 6'd0);
        check_eq("clear_score", score, 8'd40);
        check_eq("clear_flag", levelClear, 1'b1);
        tick_at(8'd0, 8'd60);
        check_eq("cleared_silent_wall", pulses_now, 5'b00000);
        tick_at(8'd50, 8'd119);
        check_eq("cleared_silent_miss", pulses_now, 5'b00000);
        check_eq("cleared_flag_sticky", levelClear, 1'b1);

        enter_level();
        check_eq("relevel_flag", levelClear, 1'b0);
        tick_at(8'd35, 8'd20);
        check_eq("relevel_map", brickMap, 40'hFF_FFFF_FFFB);
        @(negedge clock);
        ballX = 8'd0;
        ballY = 8'd60;
        tick  = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        tick  = 1'b0;
        reset = 1'b0;
        check_eq("midreset_pulses", {cX, cY, cBrickX, cBrickY, miss}, 5'b00000);
        check_eq("midreset_map", brickMap, 40'hFF_FFFF_FFFF);
        check_eq("midreset_left", bricksLeft, 6'd40);
        check_eq("midreset_score", score, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
